// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder block: read-side FSM
// encodings and the bit-reverse address helper.
package fft_pkg;

    // Widest frame address the bit-reverse helper supports.
    localparam int MAX_AWL = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no full bank waiting
        FETCH = 2'd1,   // RAM read in flight
        OUT   = 2'd2    // bin presented on the output
    } rd_state_e;

    // Reverse the low w bits of a; bits at and above w come back zero.
    function automatic logic [MAX_AWL-1:0] bitrev(input logic [MAX_AWL-1:0] a,
                                                  input int w);
        logic [MAX_AWL-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_AWL; i++) begin
            if (i < w) r[i] = a[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register only updates on a read strobe, so the last read word
// stays on rdata_o until the next read.
module fft_dp_ram #(
    parameter int DW = 32,
    parameter int AW = 11
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge CLK) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder buffer. Bins are written in natural order into one of
// two ping-pong banks; a full bank is drained oldest-first, either in
// bit-reversed or natural address order, behind a valid/ready handshake.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int DWL             = 16,
    parameter int AWL             = 11,
    parameter int BIT_REVERS_READ = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           i_VALID,
    input  logic [DWL-1:0] i_DATA_R,
    input  logic [DWL-1:0] i_DATA_I,
    input  logic           i_READY,
    output logic           o_VALID,
    output logic [DWL-1:0] o_DATA_R,
    output logic [DWL-1:0] o_DATA_I,
    output logic           o_LAST,
    output logic           OVF
);

    // write side
    logic [AWL-1:0] wr_cnt_q;
    logic           wr_bank_q;
    logic [1:0]     full_q, full_d;
    logic           ovf_q;
    logic           wr_ok, wr_en, wr_wrap, ovf_hit;

    // read side
    rd_state_e      state_q;
    logic [AWL-1:0] rd_cnt_q, rd_cnt_d;
    logic           rd_bank_q, rd_bank_d;
    logic           out_take, rel, start_idle, rd_en;
    logic [AWL-1:0] rd_addr;
    logic [MAX_AWL-1:0] cnt_ext, br_ext;

    // output registers
    logic           o_valid_q, o_last_q;
    logic [DWL-1:0] o_r_q, o_i_q;

    logic [2*DWL-1:0] rdata [2];

    // Handshake, bank release and write acceptance decisions.
    always_comb begin
        out_take   = EN && (state_q == OUT) && i_READY;
        rel        = out_take && (rd_cnt_q == '1);
        start_idle = EN && (state_q == IDLE) && full_q[rd_bank_q];
        // Next read: first bin of a newly seen bank, next bin of the current
        // bank, or straight into the other bank if it is already waiting.
        rd_en      = start_idle || (out_take && !rel) || (rel && full_q[~rd_bank_q]);
        rd_cnt_d   = rel ? '0 : (out_take ? rd_cnt_q + 1'b1 : rd_cnt_q);
        rd_bank_d  = rel ? ~rd_bank_q : rd_bank_q;

        // A bank being released this cycle is free for the incoming sample.
        wr_ok   = !full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
        wr_en   = EN && i_VALID && wr_ok;
        wr_wrap = wr_en && (wr_cnt_q == '1);
        ovf_hit = EN && i_VALID && !wr_ok;

        full_d = full_q;
        if (rel)     full_d[rd_bank_q] = 1'b0;
        if (wr_wrap) full_d[wr_bank_q] = 1'b1;
    end

    // Read address: the upcoming frame index, optionally bit-reversed.
    always_comb begin
        cnt_ext = MAX_AWL'(rd_cnt_d);
        br_ext  = bitrev(cnt_ext, AWL);
        rd_addr = (BIT_REVERS_READ != 0) ? br_ext[AWL-1:0] : rd_cnt_d;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_dp_ram #(.DW(2*DWL), .AW(AWL)) u_ram (
            .CLK     (CLK),
            .we_i    (wr_en && (wr_bank_q == 1'(b))),
            .waddr_i (wr_cnt_q),
            .wdata_i ({i_DATA_R, i_DATA_I}),
            .re_i    (rd_en && (rd_bank_d == 1'(b))),
            .raddr_i (rd_addr),
            .rdata_o (rdata[b])
        );
    end

    // Write counter, bank pointer, fill flags and sticky overflow.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (EN) begin
            full_q <= full_d;
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_wrap) wr_bank_q <= ~wr_bank_q;
            end
            if (ovf_hit) ovf_q <= 1'b1;
        end
    end

    // Read FSM with registered output bin; outputs hold while stalled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_r_q     <= '0;
            o_i_q     <= '0;
        end else if (EN) begin
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) state_q <= FETCH;
                end
                FETCH: begin
                    state_q          <= OUT;
                    o_valid_q        <= 1'b1;
                    o_last_q         <= (rd_cnt_q == '1);
                    {o_r_q, o_i_q}   <= rdata[rd_bank_q];
                end
                OUT: begin
                    if (i_READY) begin
                        o_valid_q <= 1'b0;
                        o_last_q  <= 1'b0;
                        if (rel) state_q <= full_q[~rd_bank_q] ? FETCH : IDLE;
                        else     state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_VALID  = o_valid_q;
    assign o_LAST   = o_last_q;
    assign o_DATA_R = o_r_q;
    assign o_DATA_I = o_i_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder with N=8: one bit-reversed and one
// natural-order instance share the same stimulus.
module tb_fft_out_reorder;

    localparam int DWL = 16;
    localparam int AWL = 3;
    localparam int N   = 8;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           EN = 1'b1;
    logic           i_VALID = 1'b0;
    logic           i_READY = 1'b0;
    logic [DWL-1:0] i_DATA_R = '0;
    logic [DWL-1:0] i_DATA_I = '0;

    logic           b_VALID, b_LAST, b_OVF;
    logic [DWL-1:0] b_R, b_I;
    logic           n_VALID, n_LAST, n_OVF;
    logic [DWL-1:0] n_R, n_I;

    always #5 CLK = ~CLK;

    fft_out_reorder #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_READ(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .i_VALID(i_VALID),
        .i_DATA_R(i_DATA_R), .i_DATA_I(i_DATA_I), .i_READY(i_READY),
        .o_VALID(b_VALID), .o_DATA_R(b_R), .o_DATA_I(b_I),
        .o_LAST(b_LAST), .OVF(b_OVF)
    );

    fft_out_reorder #(.DWL(DWL), .AWL(AWL), .BIT_REVERS_READ(0)) dut_nat (
        .CLK(CLK), .RST(RST), .EN(EN), .i_VALID(i_VALID),
        .i_DATA_R(i_DATA_R), .i_DATA_I(i_DATA_I), .i_READY(i_READY),
        .o_VALID(n_VALID), .o_DATA_R(n_R), .o_DATA_I(n_I),
        .o_LAST(n_LAST), .OVF(n_OVF)
    );

    typedef struct {
        logic [15:0] in_r;
        logic [15:0] exp_br;
        logic [15:0] exp_nat;
        logic        exp_last;
    } vec_t;

    vec_t vec [N];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 0;

    logic        stall_q = 1'b0;
    logic [15:0] hold_r = '0;
    logic        hold_l = 1'b0;

    logic [15:0] qb_r [$];
    logic [15:0] qb_i [$];
    logic        qb_l [$];
    logic [15:0] qn_r [$];
    logic [15:0] qn_i [$];
    logic        qn_l [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, then drive after the rising edge.
    task automatic tick();
        @(negedge CLK);
        if (RST) begin
            if (stall_q) begin
                chk("stall_valid", 32'(b_VALID), 32'd1);
                chk("stall_data",  32'(b_R), 32'(hold_r));
                chk("stall_last",  32'(b_LAST), 32'(hold_l));
            end
            if (b_VALID && i_READY && EN) begin
                qb_r.push_back(b_R); qb_i.push_back(b_I); qb_l.push_back(b_LAST);
            end
            if (n_VALID && i_READY && EN) begin
                qn_r.push_back(n_R); qn_i.push_back(n_I); qn_l.push_back(n_LAST);
            end
            stall_q = b_VALID && !i_READY && EN;
            hold_r  = b_R;
            hold_l  = b_LAST;
        end else begin
            stall_q = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rdy_mode == 1) i_READY = (cyc % 3 == 0);
    endtask

    task automatic clear_q();
        qb_r.delete(); qb_i.delete(); qb_l.delete();
        qn_r.delete(); qn_i.delete(); qn_l.delete();
    endtask

    task automatic do_reset();
        RST = 1'b0;
        i_VALID = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        clear_q();
        tick();
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int k = 0; k < N; k++) begin
            i_VALID  = 1'b1;
            i_DATA_R = 16'(base) + vec[k].in_r;
            i_DATA_I = -(16'(base) + vec[k].in_r);
            tick();
            if (gap > 0) begin
                i_VALID = 1'b0;
                repeat (gap) tick();
            end
        end
        i_VALID = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int c;
        c = 0;
        while ((qb_r.size() < n || qn_r.size() < n) && c < budget) begin
            tick();
            c++;
        end
    endtask

    // Compare captured bins against nfr frames starting at base0, base stepping by N.
    task automatic check_frames(input string nm, input int base0, input int nfr);
        logic [15:0] eb, en_, ebi, eni;
        int f, k;
        chk({nm, "_count_br"},  32'(qb_r.size()), 32'(nfr*N));
        chk({nm, "_count_nat"}, 32'(qn_r.size()), 32'(nfr*N));
        for (int idx = 0; idx < nfr*N; idx++) begin
            f   = idx / N;
            k   = idx % N;
            eb  = 16'(base0 + N*f) + vec[k].exp_br;
            en_ = 16'(base0 + N*f) + vec[k].exp_nat;
            ebi = -eb;
            eni = -en_;
            if (idx < qb_r.size()) begin
                chk({nm, "_br_r"},    32'(qb_r[idx]), 32'(eb));
                chk({nm, "_br_i"},    32'(qb_i[idx]), 32'(ebi));
                chk({nm, "_br_last"}, 32'(qb_l[idx]), 32'(vec[k].exp_last));
            end
            if (idx < qn_r.size()) begin
                chk({nm, "_nat_r"},    32'(qn_r[idx]), 32'(en_));
                chk({nm, "_nat_i"},    32'(qn_i[idx]), 32'(eni));
                chk({nm, "_nat_last"}, 32'(qn_l[idx]), 32'(vec[k].exp_last));
            end
        end
    endtask

    initial begin
        // in_r, bit-reversed output, natural output, last flag
        vec[0] = '{16'd0, 16'd0, 16'd0, 1'b0};
        vec[1] = '{16'd1, 16'd4, 16'd1, 1'b0};
        vec[2] = '{16'd2, 16'd2, 16'd2, 1'b0};
        vec[3] = '{16'd3, 16'd6, 16'd3, 1'b0};
        vec[4] = '{16'd4, 16'd1, 16'd4, 1'b0};
        vec[5] = '{16'd5, 16'd5, 16'd5, 1'b0};
        vec[6] = '{16'd6, 16'd3, 16'd6, 1'b0};
        vec[7] = '{16'd7, 16'd7, 16'd7, 1'b1};

        // Reset state
        #2;
        chk("rst_valid", 32'(b_VALID), 32'd0);
        chk("rst_last",  32'(b_LAST),  32'd0);
        chk("rst_data_r", 32'(b_R), 32'd0);
        chk("rst_data_i", 32'(b_I), 32'd0);
        chk("rst_ovf",   32'(b_OVF),   32'd0);
        do_reset();

        // Single frame, ready high: latency then bit-reversed / natural order
        i_READY = 1'b1;
        send_frame(0, 0);
        chk("lat_t0", 32'(b_VALID), 32'd0);
        tick();
        chk("lat_t1", 32'(b_VALID), 32'd0);
        tick();
        chk("lat_t2", 32'(b_VALID), 32'd1);
        chk("lat_first_r", 32'(b_R), 32'd0);
        wait_out(N, 100);
        tick(); tick(); tick();
        check_frames("single", 0, 1);
        chk("single_ovf", 32'(b_OVF), 32'd0);

        // Ready asserted one cycle in three: same order, stable while stalled
        do_reset();
        rdy_mode = 1;
        send_frame(0, 0);
        wait_out(N, 200);
        rdy_mode = 0;
        i_READY = 1'b1;
        tick(); tick();
        check_frames("stall", 0, 1);

        // Three frames with ready low: third frame dropped, overflow sticks
        do_reset();
        i_READY = 1'b0;
        send_frame(0, 0);
        send_frame(8, 0);
        chk("ovf_before", 32'(b_OVF), 32'd0);
        send_frame(16, 0);
        chk("ovf_br",  32'(b_OVF), 32'd1);
        chk("ovf_nat", 32'(n_OVF), 32'd1);
        repeat (3) tick();
        i_READY = 1'b1;
        wait_out(2*N, 200);
        repeat (20) tick();
        check_frames("ovf", 0, 2);
        chk("ovf_sticky", 32'(b_OVF), 32'd1);

        // Reset mid-frame, held-off EN, then a clean frame
        do_reset();
        i_READY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_VALID = 1'b1; i_DATA_R = 16'(k); i_DATA_I = -16'(k);
            tick();
        end
        i_VALID = 1'b0;
        RST = 1'b0;
        #1;
        chk("midrst_valid", 32'(b_VALID), 32'd0);
        chk("midrst_ovf",   32'(b_OVF),   32'd0);
        tick();
        chk("midrst_valid2", 32'(b_VALID), 32'd0);
        RST = 1'b1;
        clear_q();
        tick();
        EN = 1'b0;
        i_VALID = 1'b1; i_DATA_R = 16'd55; i_DATA_I = 16'd55;
        repeat (3) tick();
        i_VALID = 1'b0;
        EN = 1'b1;
        send_frame(100, 0);
        wait_out(N, 100);
        repeat (20) tick();
        check_frames("midrst", 100, 1);

        // Back-to-back frames, one sample every other cycle
        do_reset();
        i_READY = 1'b1;
        send_frame(0, 1);
        send_frame(8, 1);
        send_frame(16, 1);
        send_frame(24, 1);
        wait_out(4*N, 200);
        repeat (5) tick();
        check_frames("stream", 0, 4);
        chk("stream_ovf", 32'(b_OVF), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
